// File: rtl/neuron_result_collector_pkg.sv
// Shared constants, collector state enum and one-hot helpers for the neuron result path.
package nn_ctrl_pkg;

    localparam int NUM_NEURONS = 28;
    localparam int DATA_W      = 16;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } col_state_t;

    // True only when exactly one bit is set.
    function automatic logic onehot_valid(input logic [NUM_NEURONS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_NEURONS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/neuron_result_collector_if.sv
// Result stream (valid/ready) between the collector and the output/host side.
interface neuron_result_collector_if;
    import nn_ctrl_pkg::*;

    logic [DATA_W-1:0] Out_Data;
    logic [IDX_W-1:0]  Out_Index;
    logic              Out_Valid;
    logic              Out_Ready;
    logic              Out_Last;

    modport master (
        output Out_Data,
        output Out_Index,
        output Out_Valid,
        output Out_Last,
        input  Out_Ready
    );

    modport slave (
        input  Out_Data,
        input  Out_Index,
        input  Out_Valid,
        input  Out_Last,
        output Out_Ready
    );

endinterface

// File: rtl/neuron_result_collector_bank.sv
// result_bank: per-neuron result registers with one-hot write and a capture bitmap
// that masks reads of entries not written in the current frame.
module result_bank
    import nn_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   we,
    input  logic [NUM_NEURONS-1:0] sel,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DATA_W-1:0]      rd_data,
    output logic [NUM_NEURONS-1:0] bitmap
);

    logic [DATA_W-1:0] mem [NUM_NEURONS];

    // Contents need no reset: the bitmap hides stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (we && sel[i]) mem[i] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap <= '0;
        end else if (clear) begin
            bitmap <= '0;
        end else if (we) begin
            bitmap <= bitmap | sel;
        end
    end

    always_comb begin
        rd_data = '0;
        if ((rd_idx < IDX_W'(NUM_NEURONS)) && bitmap[rd_idx]) rd_data = mem[rd_idx];
    end

endmodule

// File: rtl/neuron_result_collector.sv
// Collects one signed result per neuron per frame and streams them out in index order.
// Optional argmax tracking is built when COLLECT_ARGMAX_EN is defined.
module neuron_result_collector
    import nn_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      GlobalReset,
    input  logic                      Input_Valid,
    input  logic [NUM_NEURONS-1:0]    ENX_Int,
    input  logic                      Result_Valid,
    input  logic [DATA_W-1:0]         Result_In,
    input  logic                      Output_Valid,
    neuron_result_collector_if.master out,
    output logic                      Busy,
    output logic                      Frame_Err,
    output logic [IDX_W-1:0]          Max_Index,
    output logic                      Max_Valid
);

    col_state_t state, state_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [NUM_NEURONS-1:0] bitmap, bitmap_n;
    logic [DATA_W-1:0]      rd_data;
    logic                   cap_we, bad_hot, finish, accept, last_idx, err_n;

    assign last_idx = (idx == IDX_W'(NUM_NEURONS - 1));

    // Input_Valid pre-empts every other action in CAPTURE and DRAIN.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cap_we  = 1'b0;
        bad_hot = 1'b0;
        finish  = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (Input_Valid) state_n = CAPTURE;
            end
            CAPTURE: begin
                if (!Input_Valid) begin
                    cap_we  = Result_Valid && onehot_valid(ENX_Int);
                    bad_hot = Result_Valid && !onehot_valid(ENX_Int);
                    if (Output_Valid) begin
                        finish  = 1'b1;
                        state_n = DRAIN;
                        idx_n   = '0;
                    end
                end
            end
            DRAIN: begin
                if (Input_Valid) begin
                    state_n = CAPTURE;
                    idx_n   = '0;
                end else if (out.Out_Ready) begin
                    accept = 1'b1;
                    if (last_idx) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Includes a capture landing in the same cycle as Output_Valid.
    assign bitmap_n = bitmap | (cap_we ? ENX_Int : '0);

    always_comb begin
        err_n = Frame_Err;
        if (Input_Valid && state != IDLE) begin
            err_n = (state == DRAIN);
        end else if (Input_Valid) begin
            err_n = 1'b0;
        end else if (bad_hot || (finish && !(&bitmap_n))) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state     <= IDLE;
            idx       <= '0;
            Frame_Err <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            Frame_Err <= err_n;
        end
    end

    result_bank u_bank (
        .clk    (clk),
        .rst    (GlobalReset),
        .clear  (Input_Valid),
        .we     (cap_we),
        .sel    (ENX_Int),
        .wdata  (Result_In),
        .rd_idx (idx),
        .rd_data(rd_data),
        .bitmap (bitmap)
    );

    assign out.Out_Valid = (state == DRAIN);
    assign out.Out_Data  = (state == DRAIN) ? rd_data : '0;
    assign out.Out_Index = (state == DRAIN) ? idx : '0;
    assign out.Out_Last  = (state == DRAIN) && last_idx;
    assign Busy          = (state != IDLE);

`ifdef COLLECT_ARGMAX_EN
    logic signed [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]         max_idx, cap_idx;
    logic                     have_max, max_shown;

    assign cap_idx = onehot_to_idx(ENX_Int);

    // Ties go to the lower index; rewriting the current max entry takes its new value.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            max_val   <= '0;
            max_idx   <= '0;
            have_max  <= 1'b0;
            max_shown <= 1'b0;
        end else begin
            if (Input_Valid) begin
                max_val   <= '0;
                max_idx   <= '0;
                have_max  <= 1'b0;
                max_shown <= 1'b0;
            end else begin
                if (cap_we) begin
                    if (!have_max || (cap_idx == max_idx)
                        || ($signed(Result_In) > max_val)
                        || (($signed(Result_In) == max_val) && (cap_idx < max_idx))) begin
                        max_val  <= $signed(Result_In);
                        max_idx  <= cap_idx;
                        have_max <= 1'b1;
                    end
                end
                if (finish) max_shown <= 1'b1;
            end
        end
    end

    assign Max_Index = max_shown ? max_idx : '0;
    assign Max_Valid = max_shown;
`else
    assign Max_Index = '0;
    assign Max_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_result_collector.sv
// Directed bench for neuron_result_collector: nominal, backpressure, missing entry,
// multi-hot, abort and asynchronous reset scenarios.
module tb_neuron_result_collector;
    import nn_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   GlobalReset;
    logic                   Input_Valid;
    logic [NUM_NEURONS-1:0] ENX_Int;
    logic                   Result_Valid;
    logic [DATA_W-1:0]      Result_In;
    logic                   Output_Valid;
    logic                   Busy;
    logic                   Frame_Err;
    logic [IDX_W-1:0]       Max_Index;
    logic                   Max_Valid;

    logic [DATA_W-1:0] exp_data [NUM_NEURONS];
    int n_checks = 0;
    int n_errs   = 0;

    neuron_result_collector_if out_if ();

    neuron_result_collector dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Input_Valid (Input_Valid),
        .ENX_Int     (ENX_Int),
        .Result_Valid(Result_Valid),
        .Result_In   (Result_In),
        .Output_Valid(Output_Valid),
        .out         (out_if),
        .Busy        (Busy),
        .Frame_Err   (Frame_Err),
        .Max_Index   (Max_Index),
        .Max_Valid   (Max_Valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_frame();
        Input_Valid = 1'b1;
        @(negedge clk);
        Input_Valid = 1'b0;
    endtask

    task automatic capture(input logic [NUM_NEURONS-1:0] enx, input logic [DATA_W-1:0] val);
        Result_Valid = 1'b1;
        ENX_Int      = enx;
        Result_In    = val;
        @(negedge clk);
        Result_Valid = 1'b0;
        ENX_Int      = '0;
    endtask

    task automatic end_frame();
        Output_Valid = 1'b1;
        @(negedge clk);
        Output_Valid = 1'b0;
    endtask

    // pat 0: always ready; pat 1: ready pattern 1,0,0,1 repeating.
    task automatic drain_frame(input int pat, input int nbeats);
        int   beat = 0;
        int   cyc  = 0;
        logic rdy;
        while (beat < nbeats && cyc < 200) begin
            rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            out_if.Out_Ready = rdy;
            check_val("out_valid", 32'(out_if.Out_Valid), 32'd1);
            check_val("out_index", 32'(out_if.Out_Index), 32'(beat));
            check_val("out_data",  32'(out_if.Out_Data),  32'(exp_data[beat]));
            check_val("out_last",  32'(out_if.Out_Last),  32'(beat == NUM_NEURONS - 1));
            if (rdy) beat++;
            cyc++;
            @(negedge clk);
        end
        out_if.Out_Ready = 1'b0;
        if (beat < nbeats) check_val("drain_timeout", 32'(beat), 32'(nbeats));
    endtask

    initial begin
        GlobalReset      = 1'b1;
        Input_Valid      = 1'b0;
        ENX_Int          = '0;
        Result_Valid     = 1'b0;
        Result_In        = '0;
        Output_Valid     = 1'b0;
        out_if.Out_Ready = 1'b0;
        repeat (2) @(negedge clk);
        GlobalReset = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", 32'(out_if.Out_Valid), 32'd0);
        check_val("rst_out_data",  32'(out_if.Out_Data),  32'd0);
        check_val("rst_out_index", 32'(out_if.Out_Index), 32'd0);
        check_val("rst_out_last",  32'(out_if.Out_Last),  32'd0);
        check_val("rst_busy",      32'(Busy),             32'd0);
        check_val("rst_frame_err", 32'(Frame_Err),        32'd0);
        check_val("rst_max_index", 32'(Max_Index),        32'd0);
        check_val("rst_max_valid", 32'(Max_Valid),        32'd0);

        // Nominal frame: entry k = 10*k - 100
        start_frame();
        check_val("cap_busy", 32'(Busy), 32'd1);
        for (int k = 0; k < NUM_NEURONS; k++) begin
            exp_data[k] = 16'(10 * k - 100);
            capture(NUM_NEURONS'(1) << k, 16'(10 * k - 100));
        end
        check_val("nom_pre_drain_valid", 32'(out_if.Out_Valid), 32'd0);
        end_frame();
        check_val("nom_frame_err", 32'(Frame_Err), 32'd0);
`ifdef COLLECT_ARGMAX_EN
        check_val("nom_max_index", 32'(Max_Index), 32'd27);
        check_val("nom_max_valid", 32'(Max_Valid), 32'd1);
`else
        check_val("nom_max_index", 32'(Max_Index), 32'd0);
        check_val("nom_max_valid", 32'(Max_Valid), 32'd0);
`endif
        drain_frame(0, NUM_NEURONS);
        check_val("nom_done_valid", 32'(out_if.Out_Valid), 32'd0);
        check_val("nom_done_busy",  32'(Busy),             32'd0);

        // Backpressure with entry 5 missing; previous frame left -50 in entry 5
        start_frame();
        for (int k = 0; k < NUM_NEURONS; k++) begin
            exp_data[k] = (k == 5) ? 16'd0 : 16'(7 * k + 3);
            if (k != 5) capture(NUM_NEURONS'(1) << k, 16'(7 * k + 3));
        end
        end_frame();
        check_val("miss_frame_err", 32'(Frame_Err), 32'd1);
        drain_frame(1, NUM_NEURONS);
        check_val("bp_done_busy", 32'(Busy), 32'd0);

        // Multi-hot: nothing written, error set
        start_frame();
        check_val("mh_err_cleared", 32'(Frame_Err), 32'd0);
        capture(NUM_NEURONS'(3), 16'h1234);
        check_val("mh_frame_err", 32'(Frame_Err), 32'd1);
        for (int k = 0; k < NUM_NEURONS; k++) exp_data[k] = '0;
        end_frame();
        drain_frame(0, NUM_NEURONS);

        // Abort at drain beat 10
        start_frame();
        for (int k = 0; k < NUM_NEURONS; k++) begin
            exp_data[k] = 16'(k + 1);
            capture(NUM_NEURONS'(1) << k, 16'(k + 1));
        end
        end_frame();
        check_val("ab_frame_err_pre", 32'(Frame_Err), 32'd0);
        drain_frame(0, 10);
        check_val("ab_beat10_index", 32'(out_if.Out_Index), 32'd10);
        Input_Valid = 1'b1;
        @(negedge clk);
        Input_Valid = 1'b0;
        check_val("ab_out_valid", 32'(out_if.Out_Valid), 32'd0);
        check_val("ab_busy",      32'(Busy),             32'd1);
        check_val("ab_frame_err", 32'(Frame_Err),        32'd1);
        for (int k = 0; k < NUM_NEURONS; k++) exp_data[k] = '0;
        end_frame();
        drain_frame(0, NUM_NEURONS);

        // Asynchronous reset mid-CAPTURE
        start_frame();
        capture(NUM_NEURONS'(1), 16'd5);
        capture('0, 16'd9);
        check_val("rs_pre_err",  32'(Frame_Err), 32'd1);
        check_val("rs_pre_busy", 32'(Busy),      32'd1);
        #2;
        GlobalReset = 1'b1;
        #1;
        check_val("rs_busy",      32'(Busy),             32'd0);
        check_val("rs_frame_err", 32'(Frame_Err),        32'd0);
        check_val("rs_out_valid", 32'(out_if.Out_Valid), 32'd0);
        check_val("rs_max_valid", 32'(Max_Valid),        32'd0);
        @(negedge clk);
        GlobalReset = 1'b0;
        end_frame();
        for (int i = 0; i < 4; i++) begin
            check_val("rs_no_beats", 32'(out_if.Out_Valid), 32'd0);
            @(negedge clk);
        end
        check_val("rs_idle_busy", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
